// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - qualifies POR, reset pin and PLL lock, then releases
// NUM_CHANNELS active-high resets in a fixed staggered order.
module reset_sequencer #(
  parameter int NUM_CHANNELS = 3,
  parameter int POR_CYCLES   = 32,
  parameter int LOCK_FILTER  = 8,
  parameter int STAGE_DELAY  = 4,
  parameter int FAULT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ext_rst_n,
  input  logic                    pll_locked,
  input  logic                    sw_rst_req,
  output logic [NUM_CHANNELS-1:0] rst_out,
  output logic                    ready,
  output logic [1:0]              state_o,
  output logic [FAULT_WIDTH-1:0]  fault_count
);

  localparam int POR_W   = (POR_CYCLES   > 1) ? $clog2(POR_CYCLES)   : 1;
  localparam int FILT_W  = (LOCK_FILTER  > 1) ? $clog2(LOCK_FILTER)  : 1;
  localparam int STAGE_W = (STAGE_DELAY  > 1) ? $clog2(STAGE_DELAY)  : 1;
  localparam int IDX_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  localparam logic [POR_W-1:0]   POR_LAST   = POR_W'(POR_CYCLES - 1);
  localparam logic [FILT_W-1:0]  FILT_LAST  = FILT_W'(LOCK_FILTER - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [1:0]              ext_sync, lock_sync;
  logic [POR_W-1:0]        por_cnt, por_nxt;
  logic [FILT_W-1:0]       filt_cnt, filt_nxt;
  logic [STAGE_W-1:0]      stage_cnt, stage_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [NUM_CHANNELS-1:0] rst_nxt;
  logic                    ready_nxt;
  logic [FAULT_WIDTH-1:0]  fault_nxt;
  logic                    ext_a, lock_s;

  // Chains clear to 0 so the pin reads asserted and lock reads lost after reset.
  assign ext_a   = ~ext_sync[1];
  assign lock_s  = lock_sync[1];
  assign state_o = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HOLD;
      ext_sync    <= '0;
      lock_sync   <= '0;
      por_cnt     <= '0;
      filt_cnt    <= '0;
      stage_cnt   <= '0;
      idx         <= '0;
      rst_out     <= '1;
      ready       <= 1'b0;
      fault_count <= '0;
    end else begin
      state       <= state_nxt;
      ext_sync    <= {ext_sync[0], ext_rst_n};
      lock_sync   <= {lock_sync[0], pll_locked};
      por_cnt     <= por_nxt;
      filt_cnt    <= filt_nxt;
      stage_cnt   <= stage_nxt;
      idx         <= idx_nxt;
      rst_out     <= rst_nxt;
      ready       <= ready_nxt;
      fault_count <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    por_nxt   = por_cnt;
    filt_nxt  = filt_cnt;
    stage_nxt = stage_cnt;
    idx_nxt   = idx;
    rst_nxt   = rst_out;
    ready_nxt = ready;
    fault_nxt = fault_count;

    if (ext_a) begin
      state_nxt = HOLD;
      por_nxt   = '0;
      rst_nxt   = '1;
      ready_nxt = 1'b0;
    end else if (!lock_s && (state == RELEASE || state == RUN)) begin
      // Lock loss outranks a coincident software request, which is dropped.
      state_nxt = WAIT_LOCK;
      filt_nxt  = '0;
      rst_nxt   = '1;
      ready_nxt = 1'b0;
      if (fault_count != '1)
        fault_nxt = fault_count + FAULT_WIDTH'(1);
    end else if (sw_rst_req && state != HOLD) begin
      state_nxt = HOLD;
      por_nxt   = '0;
      rst_nxt   = '1;
      ready_nxt = 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (por_cnt == POR_LAST) begin
            state_nxt = WAIT_LOCK;
            por_nxt   = '0;
            filt_nxt  = '0;
          end else begin
            por_nxt = por_cnt + POR_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (!lock_s) begin
            filt_nxt = '0;
          end else if (filt_cnt == FILT_LAST) begin
            state_nxt = RELEASE;
            filt_nxt  = '0;
            stage_nxt = '0;
            idx_nxt   = '0;
          end else begin
            filt_nxt = filt_cnt + FILT_W'(1);
          end
        end
        RELEASE: begin
          if (stage_cnt == STAGE_LAST) begin
            stage_nxt = '0;
            for (int k = 0; k < NUM_CHANNELS; k++)
              if (IDX_W'(k) == idx) rst_nxt[k] = 1'b0;
            if (idx == IDX_LAST) begin
              state_nxt = RUN;
              ready_nxt = 1'b1;
            end else begin
              idx_nxt = idx + IDX_W'(1);
            end
          end else begin
            stage_nxt = stage_cnt + STAGE_W'(1);
          end
        end
        RUN: ;
        default: state_nxt = HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed scoreboard bench for reset_sequencer.
module tb_reset_sequencer;

  localparam int N = 3, P = 32, LF = 8, SD = 4, FW = 8;
  localparam logic [1:0] S_HOLD = 2'd0, S_WL = 2'd1, S_REL = 2'd2, S_RUN = 2'd3;

  logic clk = 1'b0;
  logic reset = 1'b1, ext_rst_n = 1'b1, pll_locked = 1'b1, sw_rst_req = 1'b0;
  logic [N-1:0]  rst_out;
  logic          ready;
  logic [1:0]    state_o;
  logic [FW-1:0] fault_count;
  logic [7:0]    rst8;
  logic          rdy8;
  logic [1:0]    st8;
  logic [FW-1:0] flt8;
  logic [0:0]    rst1;
  logic          rdy1;
  logic [1:0]    st1;
  logic [FW-1:0] flt1;

  reset_sequencer #(.NUM_CHANNELS(N), .POR_CYCLES(P), .LOCK_FILTER(LF),
                    .STAGE_DELAY(SD), .FAULT_WIDTH(FW)) u0 (
    .clk(clk), .reset(reset), .ext_rst_n(ext_rst_n), .pll_locked(pll_locked),
    .sw_rst_req(sw_rst_req), .rst_out(rst_out), .ready(ready),
    .state_o(state_o), .fault_count(fault_count));

  reset_sequencer #(.NUM_CHANNELS(8), .POR_CYCLES(4), .LOCK_FILTER(2),
                    .STAGE_DELAY(1), .FAULT_WIDTH(FW)) u8 (
    .clk(clk), .reset(reset), .ext_rst_n(ext_rst_n), .pll_locked(pll_locked),
    .sw_rst_req(sw_rst_req), .rst_out(rst8), .ready(rdy8),
    .state_o(st8), .fault_count(flt8));

  reset_sequencer #(.NUM_CHANNELS(1), .POR_CYCLES(4), .LOCK_FILTER(2),
                    .STAGE_DELAY(1), .FAULT_WIDTH(FW)) u1 (
    .clk(clk), .reset(reset), .ext_rst_n(ext_rst_n), .pll_locked(pll_locked),
    .sw_rst_req(sw_rst_req), .rst_out(rst1), .ready(rdy1),
    .state_o(st1), .fault_count(flt1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [1:0]   st;
    logic [N-1:0] rst;
    logic         rdy;
    int           flt;
    string        tag;
  } exp_t;

  typedef struct {
    logic [7:0] r8;
    logic       d8;
    logic [0:0] r1;
    logic       d1;
  } sweep_t;

  exp_t   q[$];
  sweep_t sq[$];
  logic [N+2:0] prev;
  int tests = 0, fails = 0;

  function automatic logic [N+2:0] cur();
    return {state_o, rst_out, ready};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    assert (got === expv) else begin
      fails++;
      $error("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  task automatic expect_at(input int c, input logic [1:0] st, input logic [N-1:0] r,
                           input logic rd, input int f, input string tag);
    exp_t e;
    e.cyc = c; e.st = st; e.rst = r; e.rdy = rd; e.flt = f; e.tag = tag;
    q.push_back(e);
  endtask

  // Channel k drops (k+1)*SD cycles after release entry; RUN and ready come with the last.
  task automatic expect_stagger(input int t_rel, input int f, input string tag);
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) begin
      r = '1;
      r = r << (k + 1);
      if (k == N - 1) expect_at(t_rel + (k + 1) * SD, S_RUN, r, 1'b1, f, tag);
      else            expect_at(t_rel + (k + 1) * SD, S_REL, r, 1'b0, f, tag);
    end
  endtask

  task automatic check_next(input int budget);
    exp_t e;
    int n;
    n = 0;
    while (cur() === prev && n < budget) begin
      @(negedge clk);
      n++;
    end
    e = q.pop_front();
    chk({e.tag, ".seen"}, 32'(cur() !== prev), 32'd1);
    chk({e.tag, ".cycle"}, 32'(cyc), 32'(e.cyc));
    chk({e.tag, ".state"}, 32'(state_o), 32'(e.st));
    chk({e.tag, ".rst_out"}, 32'(rst_out), 32'(e.rst));
    chk({e.tag, ".ready"}, 32'(ready), 32'(e.rdy));
    chk({e.tag, ".fault"}, 32'(fault_count), 32'(e.flt));
    prev = cur();
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset(output int base);
    reset = 1'b1; ext_rst_n = 1'b1; pll_locked = 1'b1; sw_rst_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.state", 32'(state_o), 32'(S_HOLD));
    chk("reset.rst_out", 32'(rst_out), 32'(3'b111));
    chk("reset.ready", 32'(ready), 32'd0);
    chk("reset.fault", 32'(fault_count), 32'd0);
    chk("reset.rst8", 32'(rst8), 32'hFF);
    reset = 1'b0;
    base = cyc;
    prev = cur();
  endtask

  task automatic powerup(input int base, input string tag);
    expect_at(base + 2 + P, S_WL, '1, 1'b0, 0, {tag, ".wl"});
    expect_at(base + 2 + P + LF, S_REL, '1, 1'b0, 0, {tag, ".rel"});
    expect_stagger(base + 2 + P + LF, 0, tag);
    repeat (2 + N) check_next(200);
  endtask

  initial begin
    int base, t, f;
    logic [7:0] p8;

    do_reset(base);
    powerup(base, "pwr");

    // Lock glitch after 5 filtered cycles in WAIT_LOCK restarts the filter.
    do_reset(base);
    expect_at(base + 2 + P, S_WL, '1, 1'b0, 0, "glitch.wl");
    check_next(200);
    wait_cyc(base + 2 + P + 3);
    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    expect_at(base + 2 + P + 6 + LF, S_REL, '1, 1'b0, 0, "glitch.rel");
    expect_stagger(base + 2 + P + 6 + LF, 0, "glitch");
    repeat (1 + N) check_next(200);

    // Repeated lock loss in RUN; fault count saturates.
    for (int i = 1; i <= 300; i++) begin
      t = cyc;
      pll_locked = 1'b0;
      @(negedge clk);
      pll_locked = 1'b1;
      f = (i > 255) ? 255 : i;
      expect_at(t + 3, S_WL, '1, 1'b0, f, "loss.wl");
      expect_at(t + 3 + LF, S_REL, '1, 1'b0, f, "loss.rel");
      expect_stagger(t + 3 + LF, f, "loss");
      repeat (2 + N) check_next(100);
    end
    chk("loss.saturated", 32'(fault_count), 32'd255);

    // External reset pulse while rst_out=110.
    do_reset(base);
    expect_at(base + 2 + P, S_WL, '1, 1'b0, 0, "ext.wl0");
    expect_at(base + 2 + P + LF, S_REL, '1, 1'b0, 0, "ext.rel0");
    expect_at(base + 2 + P + LF + SD, S_REL, 3'b110, 1'b0, 0, "ext.ch0");
    repeat (3) check_next(200);
    t = cyc;
    ext_rst_n = 1'b0;
    @(negedge clk);
    ext_rst_n = 1'b1;
    expect_at(t + 3, S_HOLD, '1, 1'b0, 0, "ext.hold");
    expect_at(t + 3 + P, S_WL, '1, 1'b0, 0, "ext.wl");
    expect_at(t + 3 + P + LF, S_REL, '1, 1'b0, 0, "ext.rel");
    expect_stagger(t + 3 + P + LF, 0, "ext");
    repeat (3 + N) check_next(200);

    // Software request coincident with lock loss: lock loss wins, no HOLD.
    do_reset(base);
    powerup(base, "swpwr");
    t = cyc;
    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b0;
    expect_at(t + 3, S_WL, '1, 1'b0, 1, "swlock.wl");
    expect_at(t + 3 + LF, S_REL, '1, 1'b0, 1, "swlock.rel");
    expect_stagger(t + 3 + LF, 1, "swlock");
    repeat (2 + N) check_next(200);

    // Software request alone in RUN, then a request in HOLD that is ignored.
    t = cyc;
    sw_rst_req = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b0;
    expect_at(t + 1, S_HOLD, '1, 1'b0, 1, "sw.hold");
    check_next(10);
    wait_cyc(t + 10);
    sw_rst_req = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b0;
    expect_at(t + 1 + P, S_WL, '1, 1'b0, 1, "sw.wl");
    expect_at(t + 1 + P + LF, S_REL, '1, 1'b0, 1, "sw.rel");
    expect_stagger(t + 1 + P + LF, 1, "sw");
    repeat (2 + N) check_next(200);

    // Sweep: 8 and 1 channels, STAGE_DELAY=1, release entry at base+8.
    do_reset(base);
    for (int c = base + 1; c <= base + 20; c++) begin
      sweep_t s;
      int n;
      n = c - (base + 8);
      if (n < 0) n = 0;
      if (n > 8) n = 8;
      s.r8 = 8'hFF;
      s.r8 = s.r8 << n;
      s.d8 = (n >= 8);
      s.r1 = (n >= 1) ? 1'b0 : 1'b1;
      s.d1 = (n >= 1);
      sq.push_back(s);
    end
    p8 = rst8;
    for (int c = base + 1; c <= base + 20; c++) begin
      sweep_t s;
      @(negedge clk);
      s = sq.pop_front();
      chk("sweep.rst8", 32'(rst8), 32'(s.r8));
      chk("sweep.rdy8", 32'(rdy8), 32'(s.d8));
      chk("sweep.rst1", 32'(rst1), 32'(s.r1));
      chk("sweep.rdy1", 32'(rdy1), 32'(s.d1));
      chk("sweep.mono8", 32'(rst8 & ~p8), 32'd0);
      p8 = rst8;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised successor to the single power-on reset counter in the top level.
- Qualifies power-on, the external reset pin and PLL lock, then releases NUM_CHANNELS active-high reset outputs in a fixed staggered order: channel 0 first, e.g. memory, then video, then user logic.
- Re-asserts all outputs on PLL lock loss or a software request, and counts lock-loss faults.
- Sits in the top level between the system PLL / reset pin and every clock-domain consumer that needs an ordered reset.

Parameters:
- NUM_CHANNELS, 3: number of reset outputs, 1..8.
- POR_CYCLES, 32: cycles held in HOLD before lock qualification starts, >=1.
- LOCK_FILTER, 8: consecutive synchronised pll_locked=1 cycles required for qualification, >=1.
- STAGE_DELAY, 4: cycles between consecutive channel releases, >=1.
- FAULT_WIDTH, 8: width of the saturating fault counter.

Ports:
- clk  in  1  sequencer clock (free-running oscillator).
- reset  in  1  synchronous, active-high reset.
- ext_rst_n  in  1  asynchronous external reset pin, active-low; 2-FF synchronised internally.
- pll_locked  in  1  asynchronous PLL lock flag; 2-FF synchronised internally.
- sw_rst_req  in  1  synchronous single-cycle software reset request.
- rst_out  out  NUM_CHANNELS  per-channel reset, active-high.
- ready  out  1  high only in RUN, i.e. all channels released.
- state_o  out  2  current state: HOLD=0, WAIT_LOCK=1, RELEASE=2, RUN=3.
- fault_count  out  FAULT_WIDTH  lock-loss events seen in RELEASE or RUN; saturates at all-ones.

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- Values while reset=1, taking effect at the next edge:
  - state=HOLD, all counters=0, rst_out=all ones, ready=0, fault_count=0.
  - Both synchroniser chains cleared to 0: external reset reads as asserted, lock reads as lost.
- Synchronisers:
  - ext_a = ~ext_sync[1]; lock_s = lock_sync[1].
  - Pin-to-internal latency is 2 cycles.
- rst_out and ready are registered. Every rst_out bit is monotonic within a sequence: it may only fall in RELEASE and only rises together with the others.
- Event priority, evaluated every cycle in any state: ext_a > lock loss > sw_rst_req.
  - ext_a=1: next state HOLD, POR counter cleared; rst_out=all ones and ready=0 on the next cycle. HOLD keeps restarting while ext_a stays asserted.
  - lock_s=0 in RELEASE or RUN (ext_a=0): next state WAIT_LOCK, lock filter cleared, rst_out=all ones and ready=0 on the next cycle, fault_count+1 with saturation.
  - sw_rst_req=1 in WAIT_LOCK, RELEASE or RUN (no higher event): next state HOLD, all outputs asserted next cycle, fault_count unchanged.
  - sw_rst_req in HOLD is ignored.
- HOLD:
  - POR counter increments each cycle with ext_a=0.
  - When it equals POR_CYCLES-1, go to WAIT_LOCK.
  - Residence is exactly POR_CYCLES cycles after ext_a deasserts.
- WAIT_LOCK:
  - Filter counter increments while lock_s=1 and clears to 0 on any lock_s=0.
  - When it reaches LOCK_FILTER-1 with lock_s=1, go to RELEASE; stage counter=0, channel index=0.
  - Lock loss here is not a fault.
- RELEASE:
  - Stage counter increments each cycle.
  - When it reaches STAGE_DELAY-1, rst_out[index] clears on the next edge, index increments and the stage counter returns to 0.
  - Channel k is released (k+1)*STAGE_DELAY cycles after RELEASE entry.
  - When the last channel is released, state=RUN on the same edge, and ready=1 on that edge.
- RUN: holds all outputs until an event from the priority list above.
- Counter widths: each is sized with $clog2 of its terminal count, minimum 1 bit. No wrap is possible, because every counter clears on its terminal value.
- Simultaneous events: sw_rst_req in the same cycle as lock loss gives WAIT_LOCK plus one fault, with the request dropped.
- Reset mid-sequence: reset overrides everything. fault_count is cleared only by reset.

Test Plan:
- Defaults. Power-up: reset high 3 cycles, ext_rst_n=1, pll_locked=1 → HOLD for 32 cycles after the synchroniser delay, then WAIT_LOCK for 8 cycles. rst_out goes 111→110→100→000 at 4-cycle spacing; ready=1 with the last release; fault_count=0.
- Lock glitch in WAIT_LOCK: drop pll_locked for 1 cycle after 5 locked cycles → filter restarts and RELEASE begins only after 8 fresh locked cycles; fault_count stays 0.
- Lock loss in RUN: drop pll_locked → 2 cycles later plus 1, rst_out=111, ready=0, state=WAIT_LOCK, fault_count=1. Restore lock → full stagger repeats. Repeat 300 times with FAULT_WIDTH=8 → fault_count saturates at 255.
- External reset in RELEASE: pulse ext_rst_n low with rst_out=110 → rst_out=111 and state HOLD 3 cycles later; the 32-cycle HOLD restarts from release of the pin.
- sw_rst_req together with lock loss in RUN → WAIT_LOCK, fault_count+1, no HOLD. sw_rst_req alone in RUN → HOLD, rst_out=111 next cycle, fault_count unchanged.
- Parameter sweep NUM_CHANNELS=1 and 8, STAGE_DELAY=1 → channel k released k+1 cycles after RELEASE entry, ready with the last release; rst_out checked monotonic throughout.
